// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } lsu_state_t;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;

  // Result-select mux encoding for the MemoryData input.
  localparam logic [1:0] ResultMem = 2'b01;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/acknowledge data-memory bus between the LSU (master) and memory (slave).
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half lane of read data and sign- or zero-extends it.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[8*off_i +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3Lb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3Lh:    data_o = {{16{half_sel[15]}}, half_sel};
      F3Lw:    data_o = rdata_i;
      F3Lbu:   data_o = {24'h0, byte_sel};
      F3Lhu:   data_o = {16'h0, half_sel};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE -> REQ -> DONE bus FSM with lane steering and timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned Xlen    = 32,
  parameter int unsigned Timeout = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [Xlen-1:0] alu_result_i,
  input  logic [Xlen-1:0] write_data_i,
  output logic [Xlen-1:0] mem_data_o,
  output logic            stall_o,
  output logic            bus_err_o,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            misalign_trap_o,
`endif
  lsu_if.master           bus
);

  lsu_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, mem_data_q, mem_data_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        we_q, we_d, bus_err_q, bus_err_d;

  logic        access, legal, misalign, reject;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_data;

  assign access = mem_read_i | mem_write_i;
  assign legal  = f3_legal(funct3_i);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3_i[1:0] == 2'b01) & alu_result_i[0]) |
                    ((funct3_i[1:0] == 2'b10) & (alu_result_i[1:0] != 2'b00));
  assign misalign_trap_o = (state_q == StIdle) & access & legal & misalign;
`else
  assign misalign = 1'b0;
`endif

  // Accesses refused in IDLE retire immediately with zero load data.
  assign reject = (state_q == StIdle) & access & (~legal | misalign);

  always_comb begin
    case (funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_result_i[1:0];
        wdata_new = {4{write_data_i[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << {alu_result_i[1], 1'b0};
        wdata_new = {2{write_data_i[15:0]}};
      end
      default: begin
        be_new    = 4'hF;
        wdata_new = write_data_i;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .funct3_i (f3_q),
    .off_i    (off_q),
    .rdata_i  (bus.rdata),
    .data_o   (load_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    f3_d       = f3_q;
    off_d      = off_q;
    mem_data_d = mem_data_q;
    bus_err_d  = 1'b0;
    stall_o    = 1'b0;
    case (state_q)
      StIdle: begin
        if (reject) begin
          mem_data_d = '0;
        end else if (access) begin
          stall_o = 1'b1;
          addr_d  = {alu_result_i[31:2], 2'b00};
          off_d   = alu_result_i[1:0];
          be_d    = be_new;
          wdata_d = wdata_new;
          we_d    = mem_write_i;
          f3_d    = funct3_i;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        stall_o = 1'b1;
        if (bus.ack) begin
          if (!we_q) mem_data_d = load_data;
          state_d = StDone;
        end else if ((Timeout != 0) && (cnt_q == Timeout - 1)) begin
          bus_err_d  = 1'b1;
          mem_data_d = '0;
          state_d    = StDone;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      mem_data_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      mem_data_q <= mem_data_d;
      bus_err_q  <= bus_err_d;
    end
  end

  // Request decodes straight from state so an async reset drops it at once.
  assign bus.req    = (state_q == StReq);
  assign bus.we     = we_q & (state_q == StReq);
  assign bus.addr   = addr_q;
  assign bus.wdata  = wdata_q;
  assign bus.be     = (state_q == StReq) ? be_q : 4'h0;
  assign bus_err_o  = bus_err_q;
  assign mem_data_o = reject ? '0 : mem_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (Timeout = 4).
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] alu_result = '0, write_data = '0, mem_data;
  logic        stall, bus_err;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        trap;
`endif
  int          n_tests = 0;
  int          n_fail = 0;

  lsu_if bus ();

  load_store_unit #(.Xlen(32), .Timeout(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read_i   (mem_read),
    .mem_write_i  (mem_write),
    .funct3_i     (funct3),
    .alu_result_i (alu_result),
    .write_data_i (write_data),
    .mem_data_o   (mem_data),
    .stall_o      (stall),
    .bus_err_o    (bus_err),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign_trap_o (trap),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a; write_data = wd;
  endtask

  // One access with ack in the first REQ cycle; inputs held until DONE as a stalled core would.
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_mdata);
    @(posedge clk); #1 drive(rd, wr, f3, a, wd);
    @(negedge clk);
    check({tag, " idle stall"}, {31'b0, stall}, 32'd1);
    check({tag, " idle req"}, {31'b0, bus.req}, 32'd0);
    @(posedge clk); #1 bus.ack = 1'b1; bus.rdata = rdata;
    @(negedge clk);
    check({tag, " req"}, {31'b0, bus.req}, 32'd1);
    check({tag, " req stall"}, {31'b0, stall}, 32'd1);
    check({tag, " we"}, {31'b0, bus.we}, {31'b0, wr});
    check({tag, " addr"}, bus.addr, exp_addr);
    check({tag, " be"}, {28'b0, bus.be}, {28'b0, exp_be});
    if (wr) check({tag, " wdata"}, bus.wdata, exp_wdata);
    @(posedge clk); #1 bus.ack = 1'b0;
    @(negedge clk);
    check({tag, " done stall"}, {31'b0, stall}, 32'd0);
    check({tag, " done req"}, {31'b0, bus.req}, 32'd0);
    if (rd && !wr) check({tag, " mdata"}, mem_data, exp_mdata);
    @(posedge clk); #1 drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ack = 1'b0; bus.rdata = '0;
    #12;
    check("rst stall", {31'b0, stall}, 32'd0);
    check("rst req", {31'b0, bus.req}, 32'd0);
    check("rst be", {28'b0, bus.be}, 32'd0);
    check("rst err", {31'b0, bus_err}, 32'd0);
    check("rst addr", bus.addr, 32'd0);
    check("rst wdata", bus.wdata, 32'd0);
    check("rst mdata", mem_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    access("SW",  0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0);
    access("LB",  1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    access("LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 32'h100, 4'b1000, 32'h0, 32'h00000080);
    access("SH",  0, 1, 3'b001, 32'h102, 32'h1234, 32'h0, 32'h100, 4'b1100, 32'h12341234, 32'h0);
    access("LH",  1, 0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
    access("LHU", 1, 0, 3'b101, 32'h100, 32'h0, 32'h8001F00D, 32'h100, 4'b0011, 32'h0, 32'h0000F00D);
    access("SB",  0, 1, 3'b000, 32'h101, 32'hA5, 32'h0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h0);
    access("RW",  1, 1, 3'b000, 32'h100, 32'h77, 32'h0, 32'h100, 4'b0001, 32'h77777777, 32'h0);
    access("LW",  1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 32'h104, 4'hF, 32'h0, 32'hCAFEF00D);

    // Non-memory instruction: no stall, no request, load data held.
    @(negedge clk);
    check("nop stall", {31'b0, stall}, 32'd0);
    check("nop mdata", mem_data, 32'hCAFEF00D);

    // Timeout with ack withheld.
    @(posedge clk); #1 drive(1, 0, 3'b010, 32'h108, 32'h0);
    @(negedge clk);
    check("TO idle stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("TO req", {31'b0, bus.req}, 32'd1);
      check("TO no err", {31'b0, bus_err}, 32'd0);
    end
    @(negedge clk);
    check("TO err", {31'b0, bus_err}, 32'd1);
    check("TO req drop", {31'b0, bus.req}, 32'd0);
    check("TO done stall", {31'b0, stall}, 32'd0);
    check("TO mdata", mem_data, 32'd0);
    @(posedge clk); #1 drive(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("TO err pulse", {31'b0, bus_err}, 32'd0);

    // Illegal funct3.
    @(posedge clk); #1 drive(1, 0, 3'b011, 32'h100, 32'h0);
    @(negedge clk);
    check("ILL stall", {31'b0, stall}, 32'd0);
    check("ILL mdata", mem_data, 32'd0);
    @(negedge clk);
    check("ILL req", {31'b0, bus.req}, 32'd0);
    @(posedge clk); #1 drive(0, 0, 3'b000, 32'h0, 32'h0);

    // Reset mid-REQ, then stray ack.
    @(posedge clk); #1 drive(1, 0, 3'b010, 32'h10C, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("RST pre req", {31'b0, bus.req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("RST req drop", {31'b0, bus.req}, 32'd0);
    drive(0, 0, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1; bus.ack = 1'b1; bus.rdata = 32'hFFFFFFFF;
    @(negedge clk);
    check("STRAY req", {31'b0, bus.req}, 32'd0);
    check("STRAY stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    check("STRAY mdata", mem_data, 32'd0);
    @(posedge clk); #1 bus.ack = 1'b0;

`ifdef LSU_MISALIGN_TRAP_EN
    @(posedge clk); #1 drive(1, 0, 3'b010, 32'h101, 32'h0);
    @(negedge clk);
    check("MIS trap", {31'b0, trap}, 32'd1);
    check("MIS stall", {31'b0, stall}, 32'd0);
    check("MIS mdata", mem_data, 32'd0);
    @(negedge clk);
    check("MIS req", {31'b0, bus.req}, 32'd0);
    @(posedge clk); #1 drive(0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    check("MIS trap pulse", {31'b0, trap}, 32'd0);
`else
    access("LWMIS", 1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 32'h100, 4'hF, 32'h0, 32'h11223344);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
